// File: rtl/vector_reg_file_sb_if.sv
// Operand-read, writeback, scoreboard and bulk-clear signals between the decode
// stage (master) and the vector register file (slave).
interface vector_reg_file_sb_if #(
    parameter int regSize     = 16,
    parameter int regQuantity = 8,
    parameter int selBits     = 3,
    parameter int vecSize     = 4
);
    logic                              regWrEn;
    logic [selBits-1:0]                regToWrite;
    logic [vecSize-1:0]                laneMask;
    logic [vecSize-1:0][regSize-1:0]   regWriteData;
    logic [selBits-1:0]                rSel1;
    logic [selBits-1:0]                rSel2;
    logic [vecSize-1:0][regSize-1:0]   reg1Out;
    logic [vecSize-1:0][regSize-1:0]   reg2Out;
    logic                              issueEn;
    logic [selBits-1:0]                issueReg;
    logic                              busy1;
    logic                              busy2;
    logic                              clearReq;
    logic                              clearBusy;

    modport master (
        output regWrEn, regToWrite, laneMask, regWriteData, rSel1, rSel2,
               issueEn, issueReg, clearReq,
        input  reg1Out, reg2Out, busy1, busy2, clearBusy
    );

    modport slave (
        input  regWrEn, regToWrite, laneMask, regWriteData, rSel1, rSel2,
               issueEn, issueReg, clearReq,
        output reg1Out, reg2Out, busy1, busy2, clearBusy
    );
endinterface

// File: rtl/vector_reg_file_sb.sv
// Vector register file with lane-masked writeback, write-to-read bypass, a
// per-register busy scoreboard and a one-register-per-cycle bulk-clear engine.
module vector_reg_file_sb #(
    parameter int regSize     = 16,
    parameter int regQuantity = 8,
    parameter int selBits     = 3,
    parameter int vecSize     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    vector_reg_file_sb_if.slave    bus
);
    typedef logic [vecSize-1:0][regSize-1:0] vec_t;
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [selBits-1:0] LAST_IDX = selBits'(regQuantity - 1);

    state_t                 state_q;
    logic [selBits-1:0]     idx_q;
    logic                   clear_busy_q;
    vec_t                   mem_q [regQuantity];
    vec_t                   mem_d [regQuantity];
    logic [regQuantity-1:0] busy_q;
    logic [regQuantity-1:0] busy_d;
    logic                   wr_ok;
    vec_t                   rd1;
    vec_t                   rd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clearReq) begin
                        state_q      <= CLEAR;
                        idx_q        <= '0;
                        clear_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q      <= IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ok = bus.regWrEn && (state_q == IDLE);

    // Issue is applied after writeback so a same-cycle issue wins the busy bit.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (state_q == CLEAR) begin
            mem_d[idx_q]  = '0;
            busy_d[idx_q] = 1'b0;
        end else begin
            if (bus.regWrEn) begin
                for (int j = 0; j < vecSize; j++) begin
                    if (bus.laneMask[j]) mem_d[bus.regToWrite][j] = bus.regWriteData[j];
                end
                busy_d[bus.regToWrite] = 1'b0;
            end
            if (bus.issueEn) busy_d[bus.issueReg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < regQuantity; i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < regQuantity; i++) mem_q[i] <= mem_d[i];
            busy_q <= busy_d;
        end
    end

    function automatic vec_t bypass(input vec_t stored, input logic hit,
                                    input logic [vecSize-1:0] mask, input vec_t wdata);
        vec_t r;
        r = stored;
        for (int j = 0; j < vecSize; j++) begin
            if (hit && mask[j]) r[j] = wdata[j];
        end
        return r;
    endfunction

    always_comb begin
        rd1 = bypass(mem_q[bus.rSel1], wr_ok && (bus.rSel1 == bus.regToWrite),
                     bus.laneMask, bus.regWriteData);
        rd2 = bypass(mem_q[bus.rSel2], wr_ok && (bus.rSel2 == bus.regToWrite),
                     bus.laneMask, bus.regWriteData);
    end

    assign bus.reg1Out   = rd1;
    assign bus.reg2Out   = rd2;
    assign bus.busy1     = busy_q[bus.rSel1];
    assign bus.busy2     = busy_q[bus.rSel2];
    assign bus.clearBusy = clear_busy_q;
endmodule

// File: doc/vector_reg_file_sb.md
# vector_reg_file_sb

Vector register file with per-lane write masking, same-cycle write-to-read bypass, a per-register busy scoreboard, and a sequenced bulk-clear engine. It replaces the plain vector register file in the decoder stage of the SIMD processor. The decode stage reads two vector operands and checks them for hazards here. Writeback writes results with lane masks. A clear request zeroes the whole file over several cycles, for example between kernels.

## Interface
- regSize, 16: bits per lane element.
- regQuantity, 8: number of vector registers; a power of two.
- selBits, 3: register select width; equals log2(regQuantity).
- vecSize, 4: lanes per vector register.

- clk  in  1  sole clock; everything updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- regWrEn  in  1  writeback strobe.
- regToWrite  in  selBits  writeback destination register.
- laneMask  in  vecSize  per-lane write enable; bit j gates lane j.
- regWriteData  in  vecSize x regSize  writeback data, packed as [vecSize-1:0][regSize-1:0].
- rSel1, rSel2  in  selBits  read port selects.
- reg1Out, reg2Out  out  vecSize x regSize  read data, combinational.
- issueEn  in  1  marks issueReg busy (an instruction was issued that will write it).
- issueReg  in  selBits  register to mark busy.
- busy1, busy2  out  1  scoreboard bit of rSel1 / rSel2, combinational from registered state.
- clearReq  in  1  starts a bulk clear.
- clearBusy  out  1  high while the clear engine runs.

## Operation
- Storage: regQuantity x vecSize registers of regSize bits, plus a regQuantity-bit busy vector. Reset zeroes all storage and all busy bits.
- Masked write: with regWrEn=1 in IDLE, lane j of register regToWrite is loaded with regWriteData[j] only where laneMask[j]=1. Other lanes hold their value. laneMask=0 writes nothing but still clears the busy bit.
- Bypass: with regWrEn=1 in IDLE and rSelN==regToWrite, lane j of regNOut is regWriteData[j] if laneMask[j]=1, otherwise the stored lane. Otherwise regNOut is the stored value. Both ports bypass independently.
- Scoreboard:
  - A qualified writeback clears busy[regToWrite].
  - issueEn sets busy[issueReg].
  - If the same register is issued and written back in the same cycle, issue wins and the bit ends at 1.
  - busyN = busy[rSelN]. It shows the pre-edge value, with no bypass of a same-cycle clear or set.
- Clear FSM has two states, IDLE and CLEAR, plus an index counter idx of selBits bits.
  - IDLE: clearReq=1 moves to CLEAR with idx=0. The request is sampled on the edge. Writes and issues in that same cycle still apply.
  - CLEAR: each cycle zeroes every lane of register idx and clears busy[idx], then increments idx. At idx=regQuantity-1 it returns to IDLE.
  - In CLEAR, regWrEn, issueEn and clearReq are ignored, bypass is disabled, and reads return stored values, including registers not yet cleared.
  - clearBusy=1 exactly in CLEAR.
- Reset mid-clear: immediate return to IDLE with idx=0 and all storage zero.

## Timing
- Read latency is 0 cycles (combinational). A write becomes visible in stored data after the next rising edge and in the same cycle through bypass.
- A clear occupies exactly regQuantity cycles after the accepting edge. The first normal write is accepted on the edge that ends the final CLEAR cycle plus one, i.e. the first IDLE cycle.
- Reset values: reg1Out=reg2Out=0, busy1=busy2=0, clearBusy=0.
- Lane arithmetic: none. Data passes through bit-exact with no width change.

## Test plan
- Masked write: write r3 with lanes {4'hA,4'hB,4'hC,4'hD} → 16'h000A..16'h000D, laneMask=4'b0101. Next cycle, read r3 → lanes 0 and 2 updated, lanes 1 and 3 still 0.
- Bypass: in the same cycle write r5 with laneMask=4'b1111 and data 16'h1234 in all lanes, with rSel1=rSel2=5 → both outputs show 16'h1234 immediately, and the stored value matches next cycle.
- Scoreboard: issue r2 → busy1=1 next cycle with rSel1=2. Writeback r2 together with a new issue of r2 → busy stays 1. Writeback r2 alone → busy1=0 next cycle.
- Clear: fill all 8 registers and mark all busy, pulse clearReq → clearBusy high for exactly 8 cycles, a write attempted during CLEAR is dropped, and afterwards all data and busy bits are 0.
- Reset mid-clear: assert reset in the 3rd CLEAR cycle → clearBusy=0 immediately and all reads return 0. A new clearReq restarts from idx=0.
